// File: rtl/multicycle_control.sv
// Control FSM for the multicycle RV64 core: sequences fetch, decode, execute, memory and writeback.
// Define MULTICYCLE_CTRL_TRAP_EN to trap unknown opcodes and unsupported funct encodings.
module multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        alu_equal,
  input  logic        alu_greater,
  input  logic        alu_less,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCWriteState,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        LoadAOut,
  output logic        RegWrite,
  output logic        LoadRegA,
  output logic        LoadRegB,
  output logic        DMemOp,
  output logic        LoadMDR,
  output logic        IMemRead,
  output logic        IRWrite,
  output logic [1:0]  MemToReg,
  output logic [1:0]  LoadSplice,
  output logic [1:0]  StoreSplice,
  output logic        DataMemSrc,
  output logic        IntCause,
  output logic        EPCWrite,
  output logic        CauseWrite,
  output logic        halted
);

`ifdef MULTICYCLE_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD = 4'd1;
  localparam logic [3:0] ALU_SUB = 4'd2;
  localparam logic [3:0] ALU_AND = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SRA = 4'd6;

  localparam logic [1:0] SRCA_PC   = 2'd0;
  localparam logic [1:0] SRCA_A    = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_IMEM   = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_LOAD   = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  typedef enum logic [4:0] {
    FETCH, IR_LOAD, DECODE, EXEC_R, EXEC_I, EXEC_LUI, WB_ALU, ADDR,
    MEM_RD, MEM_LATCH, WB_MEM, MEM_WR, BRANCH, PC_INC, JAL1, JAL2,
    JALR1, JALR2, HALT, EXC1, EXC2, EXC3
  } state_t;

  state_t state, state_nxt, state_tgt, dispatch;
  logic   booted;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       r_ok, i_ok, ld_ok, st_ok, br_ok, funct_trap, taken;
  logic [3:0] r_op, i_op;
  logic [1:0] load_splice, store_splice;
  logic       unused_bits;

  logic       PCWrite_d, PCWriteCond_d, LoadAOut_d, RegWrite_d, LoadRegA_d, LoadRegB_d;
  logic       DMemOp_d, LoadMDR_d, IMemRead_d, IRWrite_d;
  logic       DataMemSrc_d, IntCause_d, EPCWrite_d, CauseWrite_d, halted_d;
  logic [1:0] PCSource_d, ALUSrcA_d, ALUSrcB_d, MemToReg_d, LoadSplice_d, StoreSplice_d;
  logic [3:0] ALUOp_d;
  logic       pc_inc;

  assign opcode      = instruction[6:0];
  assign funct3      = instruction[14:12];
  assign funct7      = instruction[31:25];
  assign unused_bits = ^{alu_zero, instruction[24:15], instruction[11:7]};

  // Funct-field decode: supported encodings, ALU operation and access size
  always_comb begin
    r_ok         = 1'b0;
    r_op         = ALU_ADD;
    i_ok         = 1'b1;
    i_op         = ALU_ADD;
    ld_ok        = 1'b1;
    load_splice  = 2'd0;
    st_ok        = 1'b1;
    store_splice = 2'd0;
    br_ok        = 1'b1;
    taken        = 1'b0;
    if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
      r_ok = 1'b1;
    end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
      r_ok = 1'b1;
      r_op = ALU_SUB;
    end else if (funct3 == 3'b111 && funct7 == 7'b0000000) begin
      r_ok = 1'b1;
      r_op = ALU_AND;
    end
    case (funct3)
      3'b000:  i_op = ALU_ADD;
      3'b001:  i_op = ALU_SLL;
      3'b101:  i_op = instruction[30] ? ALU_SRA : ALU_SRL;
      default: i_ok = 1'b0;
    endcase
    case (funct3)
      3'b011:  load_splice = 2'd0;
      3'b010:  load_splice = 2'd1;
      3'b001:  load_splice = 2'd2;
      3'b100:  load_splice = 2'd3;
      default: ld_ok = 1'b0;
    endcase
    case (funct3)
      3'b011:  store_splice = 2'd0;
      3'b010:  store_splice = 2'd1;
      3'b001:  store_splice = 2'd2;
      3'b000:  store_splice = 2'd3;
      default: st_ok = 1'b0;
    endcase
    case (funct3)
      3'b000:  taken = alu_equal;
      3'b001:  taken = !alu_equal;
      3'b100:  taken = alu_less;
      3'b101:  taken = alu_greater | alu_equal;
      default: br_ok = 1'b0;
    endcase
  end

  // Opcodes whose trap reason is a bad funct field rather than an unknown opcode
  assign funct_trap = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                      (opcode == OP_STORE) || (opcode == OP_BRANCH);

  assign PCWriteState = PCWrite | (PCWriteCond & taken);

  always_comb begin
    dispatch = TRAP_EN ? EXC1 : PC_INC;
    case (opcode)
      OP_R:      dispatch = (r_ok  || !TRAP_EN) ? EXEC_R : EXC1;
      OP_I:      dispatch = (i_ok  || !TRAP_EN) ? EXEC_I : EXC1;
      OP_LUI:    dispatch = EXEC_LUI;
      OP_LOAD:   dispatch = (ld_ok || !TRAP_EN) ? ADDR : EXC1;
      OP_STORE:  dispatch = (st_ok || !TRAP_EN) ? ADDR : EXC1;
      OP_BRANCH: dispatch = (br_ok || !TRAP_EN) ? BRANCH : EXC1;
      OP_JAL:    dispatch = JAL1;
      OP_JALR:   dispatch = JALR1;
      OP_SYSTEM: dispatch = HALT;
      default:   ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:     state_nxt = IR_LOAD;
      IR_LOAD:   state_nxt = DECODE;
      DECODE:    state_nxt = dispatch;
      EXEC_R, EXEC_I, EXEC_LUI: state_nxt = WB_ALU;
      ADDR:      state_nxt = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:    state_nxt = MEM_LATCH;
      MEM_LATCH: state_nxt = WB_MEM;
      BRANCH:    state_nxt = taken ? FETCH : PC_INC;
      JAL1:      state_nxt = JAL2;
      JALR1:     state_nxt = JALR2;
      HALT:      state_nxt = HALT;
      EXC1:      state_nxt = EXC2;
      EXC2:      state_nxt = EXC3;
      default:   state_nxt = FETCH;
    endcase
    // First edge after reset re-enters FETCH so its outputs become visible
    state_tgt = booted ? state_nxt : FETCH;
  end

  // Outputs for the state being entered; registered alongside the state
  always_comb begin
    pc_inc        = 1'b0;
    PCWrite_d     = 1'b0;
    PCWriteCond_d = 1'b0;
    PCSource_d    = 2'd0;
    ALUSrcA_d     = 2'd0;
    ALUSrcB_d     = 2'd0;
    ALUOp_d       = 4'd0;
    LoadAOut_d    = 1'b0;
    RegWrite_d    = 1'b0;
    LoadRegA_d    = 1'b0;
    LoadRegB_d    = 1'b0;
    DMemOp_d      = 1'b0;
    LoadMDR_d     = 1'b0;
    IMemRead_d    = 1'b0;
    IRWrite_d     = 1'b0;
    MemToReg_d    = 2'd0;
    LoadSplice_d  = 2'd0;
    StoreSplice_d = 2'd0;
    DataMemSrc_d  = 1'b0;
    IntCause_d    = 1'b0;
    EPCWrite_d    = 1'b0;
    CauseWrite_d  = 1'b0;
    halted_d      = 1'b0;
    case (state_tgt)
      FETCH:   IMemRead_d = 1'b1;
      IR_LOAD: IRWrite_d = 1'b1;
      DECODE: begin
        LoadRegA_d = 1'b1;
        LoadRegB_d = 1'b1;
        ALUSrcA_d  = SRCA_PC;
        ALUSrcB_d  = SRCB_IMM;
        ALUOp_d    = ALU_ADD;
        LoadAOut_d = 1'b1;
      end
      EXEC_R: begin
        ALUSrcA_d  = SRCA_A;
        ALUSrcB_d  = SRCB_B;
        ALUOp_d    = r_op;
        LoadAOut_d = 1'b1;
      end
      EXEC_I: begin
        ALUSrcA_d  = SRCA_A;
        ALUSrcB_d  = SRCB_IMM;
        ALUOp_d    = i_op;
        LoadAOut_d = 1'b1;
      end
      EXEC_LUI: begin
        ALUSrcA_d  = SRCA_ZERO;
        ALUSrcB_d  = SRCB_IMM;
        ALUOp_d    = ALU_ADD;
        LoadAOut_d = 1'b1;
      end
      ADDR: begin
        ALUSrcA_d  = SRCA_A;
        ALUSrcB_d  = SRCB_IMM;
        ALUOp_d    = ALU_ADD;
        LoadAOut_d = 1'b1;
      end
      WB_ALU: begin
        RegWrite_d = 1'b1;
        MemToReg_d = WB_ALUOUT;
        pc_inc     = 1'b1;
      end
      MEM_LATCH: LoadMDR_d = 1'b1;
      WB_MEM: begin
        RegWrite_d   = 1'b1;
        MemToReg_d   = WB_LOAD;
        LoadSplice_d = load_splice;
        pc_inc       = 1'b1;
      end
      MEM_WR: begin
        DMemOp_d      = 1'b1;
        StoreSplice_d = store_splice;
        pc_inc        = 1'b1;
      end
      BRANCH: begin
        ALUSrcA_d     = SRCA_A;
        ALUSrcB_d     = SRCB_B;
        ALUOp_d       = ALU_SUB;
        PCWriteCond_d = 1'b1;
        PCSource_d    = PCSRC_ALUOUT;
      end
      PC_INC, JAL1, JALR1: pc_inc = 1'b1;
      JAL2: begin
        RegWrite_d = 1'b1;
        MemToReg_d = WB_PC;
        PCSource_d = PCSRC_ALUOUT;
        PCWrite_d  = 1'b1;
      end
      JALR2: begin
        ALUSrcA_d  = SRCA_A;
        ALUSrcB_d  = SRCB_IMM;
        ALUOp_d    = ALU_ADD;
        PCSource_d = PCSRC_ALU;
        PCWrite_d  = 1'b1;
        RegWrite_d = 1'b1;
        MemToReg_d = WB_PC;
      end
      HALT: halted_d = 1'b1;
      EXC1: begin
        pc_inc     = 1'b1;
        IntCause_d = funct_trap;
      end
      EXC2: begin
        EPCWrite_d   = 1'b1;
        CauseWrite_d = 1'b1;
        DataMemSrc_d = 1'b1;
        IntCause_d   = funct_trap;
      end
      EXC3: begin
        DataMemSrc_d = 1'b1;
        PCSource_d   = PCSRC_IMEM;
        PCWrite_d    = 1'b1;
        IntCause_d   = funct_trap;
      end
      default: ;
    endcase
    if (pc_inc) begin
      ALUSrcA_d  = SRCA_PC;
      ALUSrcB_d  = SRCB_FOUR;
      ALUOp_d    = ALU_ADD;
      PCSource_d = PCSRC_ALU;
      PCWrite_d  = 1'b1;
    end
`ifndef MULTICYCLE_CTRL_TRAP_EN
    DataMemSrc_d = 1'b0;
    IntCause_d   = 1'b0;
    EPCWrite_d   = 1'b0;
    CauseWrite_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      booted      <= 1'b0;
      PCWrite     <= 1'b0;
      PCWriteCond <= 1'b0;
      PCSource    <= 2'd0;
      ALUSrcA     <= 2'd0;
      ALUSrcB     <= 2'd0;
      ALUOp       <= 4'd0;
      LoadAOut    <= 1'b0;
      RegWrite    <= 1'b0;
      LoadRegA    <= 1'b0;
      LoadRegB    <= 1'b0;
      DMemOp      <= 1'b0;
      LoadMDR     <= 1'b0;
      IMemRead    <= 1'b0;
      IRWrite     <= 1'b0;
      MemToReg    <= 2'd0;
      LoadSplice  <= 2'd0;
      StoreSplice <= 2'd0;
      DataMemSrc  <= 1'b0;
      IntCause    <= 1'b0;
      EPCWrite    <= 1'b0;
      CauseWrite  <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state       <= state_tgt;
      booted      <= 1'b1;
      PCWrite     <= PCWrite_d;
      PCWriteCond <= PCWriteCond_d;
      PCSource    <= PCSource_d;
      ALUSrcA     <= ALUSrcA_d;
      ALUSrcB     <= ALUSrcB_d;
      ALUOp       <= ALUOp_d;
      LoadAOut    <= LoadAOut_d;
      RegWrite    <= RegWrite_d;
      LoadRegA    <= LoadRegA_d;
      LoadRegB    <= LoadRegB_d;
      DMemOp      <= DMemOp_d;
      LoadMDR     <= LoadMDR_d;
      IMemRead    <= IMemRead_d;
      IRWrite     <= IRWrite_d;
      MemToReg    <= MemToReg_d;
      LoadSplice  <= LoadSplice_d;
      StoreSplice <= StoreSplice_d;
      DataMemSrc  <= DataMemSrc_d;
      IntCause    <= IntCause_d;
      EPCWrite    <= EPCWrite_d;
      CauseWrite  <= CauseWrite_d;
      halted      <= halted_d;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction expected control sequences from an ISA-level model.
module tb_multicycle_control;

`ifdef MULTICYCLE_CTRL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [3:0] ADD = 4'd1;
  localparam logic [3:0] SUB = 4'd2;
  localparam logic [3:0] AND_OP = 4'd3;
  localparam logic [3:0] SLL = 4'd4;
  localparam logic [3:0] SRL = 4'd5;
  localparam logic [3:0] SRA = 4'd6;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       pc_write_state;
    logic [1:0] pc_source;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic       load_aout;
    logic       reg_write;
    logic       load_a;
    logic       load_b;
    logic       dmem_op;
    logic       load_mdr;
    logic       imem_read;
    logic       ir_write;
    logic [1:0] mem_to_reg;
    logic [1:0] load_splice;
    logic [1:0] store_splice;
    logic       data_mem_src;
    logic       int_cause;
    logic       epc_write;
    logic       cause_write;
    logic       halted;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] instruction;
  logic alu_zero, alu_equal, alu_greater, alu_less;
  logic PCWrite, PCWriteCond, PCWriteState;
  logic [1:0] PCSource, ALUSrcA, ALUSrcB, MemToReg, LoadSplice, StoreSplice;
  logic [3:0] ALUOp;
  logic LoadAOut, RegWrite, LoadRegA, LoadRegB, DMemOp, LoadMDR, IMemRead, IRWrite;
  logic DataMemSrc, IntCause, EPCWrite, CauseWrite, halted;

  ctl_t obs;
  ctl_t exp_q[$];
  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .alu_zero(alu_zero), .alu_equal(alu_equal), .alu_greater(alu_greater), .alu_less(alu_less),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteState(PCWriteState),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .LoadAOut(LoadAOut), .RegWrite(RegWrite), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
    .DMemOp(DMemOp), .LoadMDR(LoadMDR), .IMemRead(IMemRead), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .LoadSplice(LoadSplice), .StoreSplice(StoreSplice),
    .DataMemSrc(DataMemSrc), .IntCause(IntCause), .EPCWrite(EPCWrite),
    .CauseWrite(CauseWrite), .halted(halted)
  );

  assign obs = {PCWrite, PCWriteCond, PCWriteState, PCSource, ALUSrcA, ALUSrcB, ALUOp,
                LoadAOut, RegWrite, LoadRegA, LoadRegB, DMemOp, LoadMDR, IMemRead, IRWrite,
                MemToReg, LoadSplice, StoreSplice, DataMemSrc, IntCause, EPCWrite,
                CauseWrite, halted};

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic ctl_t alu_step(input logic [1:0] a, input logic [1:0] b, input logic [3:0] op);
    ctl_t c = '0;
    c.src_a = a;
    c.src_b = b;
    c.alu_op = op;
    c.load_aout = 1'b1;
    return c;
  endfunction

  function automatic ctl_t pc_plus4();
    ctl_t c = '0;
    c.src_b = 2'd1;
    c.alu_op = ADD;
    c.pc_write = 1'b1;
    c.pc_write_state = 1'b1;
    return c;
  endfunction

  task automatic push_wb_alu();
    ctl_t c = pc_plus4();
    c.reg_write = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic push_trap(input logic cause);
    ctl_t c = pc_plus4();
    c.int_cause = cause;
    exp_q.push_back(c);
    c = '0;
    c.epc_write = 1'b1;
    c.cause_write = 1'b1;
    c.data_mem_src = 1'b1;
    c.int_cause = cause;
    exp_q.push_back(c);
    c = '0;
    c.data_mem_src = 1'b1;
    c.pc_source = 2'd2;
    c.pc_write = 1'b1;
    c.pc_write_state = 1'b1;
    c.int_cause = cause;
    exp_q.push_back(c);
  endtask

  // Cycle-by-cycle control expected for one instruction, FETCH through the cycle before the next FETCH
  task automatic build_expected(input logic [31:0] ins, input logic eq, input logic gt, input logic ls);
    ctl_t c;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] k;
    logic [1:0] sp;
    logic bad, tk;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    bad = 1'b0;
    tk = 1'b0;
    k = ADD;
    sp = 2'd0;
    exp_q.delete();
    c = '0; c.imem_read = 1'b1; exp_q.push_back(c);
    c = '0; c.ir_write = 1'b1; exp_q.push_back(c);
    c = alu_step(2'd0, 2'd2, ADD); c.load_a = 1'b1; c.load_b = 1'b1; exp_q.push_back(c);
    case (op)
      OP_R: begin
        if (f3 == 3'b000 && f7 == 7'h00) k = ADD;
        else if (f3 == 3'b000 && f7 == 7'h20) k = SUB;
        else if (f3 == 3'b111 && f7 == 7'h00) k = AND_OP;
        else bad = 1'b1;
        if (bad && TRAP) push_trap(1'b1);
        else begin exp_q.push_back(alu_step(2'd1, 2'd0, k)); push_wb_alu(); end
      end
      OP_I: begin
        if (f3 == 3'b000) k = ADD;
        else if (f3 == 3'b001) k = SLL;
        else if (f3 == 3'b101) k = ins[30] ? SRA : SRL;
        else bad = 1'b1;
        if (bad && TRAP) push_trap(1'b1);
        else begin exp_q.push_back(alu_step(2'd1, 2'd2, k)); push_wb_alu(); end
      end
      OP_LUI: begin
        exp_q.push_back(alu_step(2'd2, 2'd2, ADD));
        push_wb_alu();
      end
      OP_LOAD: begin
        case (f3)
          3'b011: sp = 2'd0;
          3'b010: sp = 2'd1;
          3'b001: sp = 2'd2;
          3'b100: sp = 2'd3;
          default: bad = 1'b1;
        endcase
        if (bad && TRAP) push_trap(1'b1);
        else begin
          exp_q.push_back(alu_step(2'd1, 2'd2, ADD));
          c = '0; exp_q.push_back(c);
          c.load_mdr = 1'b1; exp_q.push_back(c);
          c = pc_plus4(); c.reg_write = 1'b1; c.mem_to_reg = 2'd1; c.load_splice = sp;
          exp_q.push_back(c);
        end
      end
      OP_STORE: begin
        case (f3)
          3'b011: sp = 2'd0;
          3'b010: sp = 2'd1;
          3'b001: sp = 2'd2;
          3'b000: sp = 2'd3;
          default: bad = 1'b1;
        endcase
        if (bad && TRAP) push_trap(1'b1);
        else begin
          exp_q.push_back(alu_step(2'd1, 2'd2, ADD));
          c = pc_plus4(); c.dmem_op = 1'b1; c.store_splice = sp;
          exp_q.push_back(c);
        end
      end
      OP_BRANCH: begin
        case (f3)
          3'b000: tk = eq;
          3'b001: tk = !eq;
          3'b100: tk = ls;
          3'b101: tk = gt | eq;
          default: bad = 1'b1;
        endcase
        if (bad && TRAP) push_trap(1'b1);
        else begin
          c = '0; c.src_a = 2'd1; c.alu_op = SUB; c.pc_write_cond = 1'b1;
          c.pc_source = 2'd1; c.pc_write_state = tk;
          exp_q.push_back(c);
          if (!tk) exp_q.push_back(pc_plus4());
        end
      end
      OP_JAL: begin
        exp_q.push_back(pc_plus4());
        c = '0; c.reg_write = 1'b1; c.mem_to_reg = 2'd2; c.pc_source = 2'd1;
        c.pc_write = 1'b1; c.pc_write_state = 1'b1;
        exp_q.push_back(c);
      end
      OP_JALR: begin
        exp_q.push_back(pc_plus4());
        c = '0; c.src_a = 2'd1; c.src_b = 2'd2; c.alu_op = ADD; c.pc_write = 1'b1;
        c.pc_write_state = 1'b1; c.reg_write = 1'b1; c.mem_to_reg = 2'd2;
        exp_q.push_back(c);
      end
      OP_SYSTEM: begin
        c = '0; c.halted = 1'b1; exp_q.push_back(c);
      end
      default: begin
        if (TRAP) push_trap(1'b0);
        else exp_q.push_back(pc_plus4());
      end
    endcase
  endtask

  // Called one step after the edge that enters FETCH; returns one step after the next FETCH edge
  task automatic run_seq(input string name);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i + 1, obs, exp_q[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [31:0] ins,
                           input logic eq, input logic gt, input logic ls);
    instruction = ins;
    alu_equal = eq;
    alu_greater = gt;
    alu_less = ls;
    alu_zero = eq;
    build_expected(ins, eq, gt, ls);
    run_seq(name);
  endtask

  function automatic logic is_known(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_LUI, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_SYSTEM};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] op;
    int kind;
    r = $urandom;
    kind = int'($urandom_range(0, 8));
    case (kind)
      0: begin
        r[6:0] = OP_R;
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          default: ;
        endcase
      end
      1: r[6:0] = OP_I;
      2: r[6:0] = OP_LUI;
      3: r[6:0] = OP_LOAD;
      4: r[6:0] = OP_STORE;
      5: r[6:0] = OP_BRANCH;
      6: r[6:0] = OP_JAL;
      7: r[6:0] = OP_JALR;
      default: begin
        op = 7'($urandom);
        while (is_known(op)) op = 7'($urandom);
        r[6:0] = op;
      end
    endcase
    return r;
  endfunction

  task automatic test_reset();
    instruction = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs, ctl_t'('0));
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu_ops();
    run_instr("add", 32'h002081B3, 1'b0, 1'b0, 1'b0);
    run_instr("sub", 32'h402081B3, 1'b0, 1'b0, 1'b0);
    run_instr("and", 32'h0020F1B3, 1'b0, 1'b0, 1'b0);
    run_instr("addi", 32'h00108093, 1'b0, 1'b0, 1'b0);
    run_instr("slli", 32'h00309093, 1'b0, 1'b0, 1'b0);
    run_instr("srli", 32'h0030D093, 1'b0, 1'b0, 1'b0);
    run_instr("srai", 32'h4030D093, 1'b0, 1'b0, 1'b0);
    run_instr("lui", 32'h123450B7, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 32'h00208063, 1'b1, 1'b0, 1'b0);
    run_instr("beq_not_taken", 32'h00208063, 1'b0, 1'b1, 1'b0);
    run_instr("bne_taken", 32'h00209063, 1'b0, 1'b0, 1'b1);
    run_instr("blt_taken", 32'h0020C063, 1'b0, 1'b0, 1'b1);
    run_instr("blt_not_taken", 32'h0020C063, 1'b0, 1'b1, 1'b0);
    run_instr("bge_equal", 32'h0020D063, 1'b1, 1'b0, 1'b0);
    run_instr("bge_less", 32'h0020D063, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_load_store();
    run_instr("ld", 32'h0000B283, 1'b0, 1'b0, 1'b0);
    run_instr("lw", 32'h0000A283, 1'b0, 1'b0, 1'b0);
    run_instr("lbu", 32'h0000C283, 1'b0, 1'b0, 1'b0);
    run_instr("sb", 32'h00208023, 1'b0, 1'b0, 1'b0);
    run_instr("sd", 32'h0020B023, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_jumps();
    run_instr("jal", 32'h000000EF, 1'b0, 1'b0, 1'b0);
    run_instr("jalr", 32'h000080E7, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_unknown();
    run_instr("opcode_7f", 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    run_instr("r_bad_funct", 32'h0020C1B3, 1'b0, 1'b0, 1'b0);
    run_instr("branch_bad_funct", 32'h0020A063, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 80; n++) begin
      ins = rand_instr();
      run_instr("random", ins, 1'($urandom), 1'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    instruction = 32'h0020B023;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (DMemOp !== 1'b1) begin
      errors++;
      $display("FAIL mem_wr_before_reset: DMemOp got %b expected 1", DMemOp);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL async_reset_mid: got %h expected %h", obs, ctl_t'('0));
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_instr("after_reset", 32'h00108093, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_halt();
    ctl_t h;
    instruction = 32'h00100073;
    build_expected(32'h00100073, 1'b0, 1'b0, 1'b0);
    h = '0;
    h.halted = 1'b1;
    for (int i = 0; i < 99; i++) exp_q.push_back(h);
    run_seq("halt");
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL halt_reset: got %h expected %h", obs, ctl_t'('0));
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run_instr("after_halt", 32'h002081B3, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    instruction = 32'h0;
    alu_zero = 1'b0;
    alu_equal = 1'b0;
    alu_greater = 1'b0;
    alu_less = 1'b0;
    test_reset();
    test_alu_ops();
    test_branch();
    test_load_store();
    test_jumps();
    test_unknown();
    test_random();
    test_reset_mid();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy control FSM for the multicycle RV64 core.
- Sits directly upstream of the processing datapath and drives every control flag it consumes.
- Consumes the datapath's instruction_out and the ALU compare flags: alu_zero, alu_equal, alu_greater, alu_less.
- Sequences fetch, decode, execute, memory and writeback, and resolves PC writes.

Parameters:
None.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- instruction  in  32  IR contents (datapath instruction_out)
- alu_zero / alu_equal / alu_greater / alu_less  in  1 each  ALU flags
- PCWrite, PCWriteCond, PCWriteState  out  1 each  PC write request / conditional request / resolved PC load
- PCSource  out  2  0 = ALU result, 1 = ALUOut register, 2 = instruction-memory word
- ALUSrcA  out  2  0 = PC, 1 = A, 2 = zero
- ALUSrcB  out  2  0 = B, 1 = 4, 2 = imm
- ALUOp  out  4  ADD=1, SUB=2, AND=3, SLL=4, SRL=5, SRA=6
- LoadAOut, RegWrite, LoadRegA, LoadRegB, DMemOp, LoadMDR, IMemRead, IRWrite  out  1 each
- MemToReg  out  2  0 = ALUOut, 1 = load data, 2 = PC
- LoadSplice, StoreSplice  out  2 each  0 = dword, 1 = word, 2 = half, 3 = byte
- DataMemSrc, IntCause, EPCWrite, CauseWrite  out  1 each  trap controls
- halted  out  1  high in HALT

Behaviour:
- Output rules
  - Every output is 0 unless listed for the current state.
  - PCWriteState = PCWrite | (PCWriteCond & taken).
  - Asynchronous reset: state = FETCH; all outputs 0 while reset is high.
  - Reset mid-instruction abandons the instruction with no partial write.
- Common path (all instructions)
  - FETCH: IMemRead=1.
  - IR_LOAD: IRWrite=1.
  - DECODE: LoadRegA=LoadRegB=1; ALU = PC + imm (SrcA=0, SrcB=2, ADD); LoadAOut=1. ALUOut now holds the branch/jump target.
- Dispatch from DECODE on opcode, instruction[6:0]
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0110111 → EXEC_LUI
  - 0000011 / 0100011 → ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL1
  - 1100111 → JALR1
  - 1110011 → HALT
  - other → PC_INC (macro off) or EXC1 (macro on)
- EXEC_R: A op B, LoadAOut=1.
  - funct7/funct3 0000000/000 → ADD; 0100000/000 → SUB; 0000000/111 → AND.
  - → WB_ALU.
- EXEC_I: A op imm, LoadAOut=1.
  - funct3 000 → ADD; 001 → SLL; 101 → SRL, or SRA when instruction[30]=1.
  - → WB_ALU.
- EXEC_LUI: SrcA=2, SrcB=2, ADD, LoadAOut=1 → WB_ALU.
- WB_ALU: RegWrite=1, MemToReg=0; in the same cycle PC+4 (SrcA=0, SrcB=1, ADD, PCSource=0, PCWrite=1); LoadAOut=0 → FETCH.
- ADDR: A + imm, LoadAOut=1 → MEM_RD for loads, MEM_WR for stores.
- MEM_RD: DMemOp=0 (one-cycle synchronous read).
- MEM_LATCH: LoadMDR=1.
- WB_MEM: RegWrite=1, MemToReg=1, LoadSplice from funct3 (011→0, 010→1, 001→2, 100→3); PC+4 as in WB_ALU → FETCH.
- MEM_WR: DMemOp=1, StoreSplice from funct3 (011→0, 010→1, 001→2, 000→3); PC+4 → FETCH.
- BRANCH: SrcA=1, SrcB=0, SUB; PCWriteCond=1, PCSource=1.
  - Taken: funct3 000 → equal; 001 → !equal; 100 → less; 101 → greater|equal.
  - Taken → FETCH. Not taken → PC_INC.
- PC_INC: PC+4 → FETCH.
- JAL1: PC+4 without LoadAOut.
- JAL2: RegWrite=1, MemToReg=2 (writes PC+4); PCSource=1, PCWrite=1 → FETCH.
- JALR1: PC+4.
- JALR2: SrcA=1, SrcB=2, ADD; PCSource=0, PCWrite=1; RegWrite=1, MemToReg=2 → FETCH.
- HALT: halted=1; no writes; remains until reset.
- Latency, counted from FETCH entry to the next FETCH:
  - R / I / LUI / store / JAL / JALR: 5 cycles
  - load: 7 cycles
  - branch taken: 4 cycles; not taken: 5 cycles

Optional Feature:
- Macro: MULTICYCLE_CTRL_TRAP_EN.
- Defined:
  - Unknown opcode → EXC1. Cause 0.
  - Known opcode with unsupported funct (EXEC_R/EXEC_I/loads/stores/branches) → EXC1 with IntCause=1 held through the trap. Cause 1.
  - EXC1: PC+4.
  - EXC2: EPCWrite=1, CauseWrite=1, DataMemSrc=1.
  - EXC3: DataMemSrc=1, PCSource=2, PCWrite=1 → FETCH.
  - Trap latency: 6 cycles.
- Undefined:
  - Unknown opcode → PC_INC, executed as a NOP.
  - Unsupported funct executes as ADD.
  - EPCWrite, CauseWrite, DataMemSrc and IntCause are tied to 0.

Test Plan:
- add x3,x1,x2 with x1=5, x2=7 → RegWrite pulses at cycle 5 with ALUOp=1; PC advances 0→4; next IRWrite at cycle 7.
- beq with equal=1 → PCWriteState=1, PCSource=1 in cycle 4; next FETCH at cycle 5. With equal=0 → PC_INC in cycle 5, PC+4.
- ld (funct3 011) → LoadMDR at cycle 6; RegWrite, MemToReg=1, LoadSplice=0 at cycle 7. sb → DMemOp=1, StoreSplice=3 at cycle 5.
- jal → cycle 4 PCWrite with PCSource=0; cycle 5 RegWrite with MemToReg=2 plus PCWrite with PCSource=1.
- Opcode 1111111:
  - macro on → EPCWrite=CauseWrite=1, IntCause=0 at cycle 5; PCSource=2 at cycle 6.
  - macro off → only PC+4.
- Reset asserted in MEM_WR → DMemOp drops to 0 asynchronously; after release, IMemRead=1 in FETCH. ebreak → halted=1 persists for 100 cycles.
